multi_cycle_cpu: RTL

- Parametrised multi-cycle RISC-V core; successor to the single-cycle datapath.
- One unified memory port with a valid/ready handshake replaces the separate instruction and data memories. Memory latency is arbitrary.
- Internal 32-entry register file, ALU, immediate generation, FSM sequencer.
- Sits between the clock generator and a shared memory model; it is the top-level core under the SoC wrapper.

---
 rtl/multi_cycle_cpu.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_cpu.sv
// ============================================================================
// Module   : multi_cycle_cpu
// Purpose  : Multi-cycle RV core (add/sub/and/or/addi/load/store/beq) on one
//            valid/ready memory port. Optional macro MULTI_CYCLE_CPU_TRAP_EN
//            halts on illegal instructions instead of treating them as NOPs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_cpu #(
    parameter int                    XLEN       = 64,
    parameter int                    ADDR_WIDTH = 48,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clockInput,
    input  logic                  resetInput,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [XLEN-1:0]       memWData,
    input  logic [XLEN-1:0]       memRData,
    input  logic                  memReady,
    output logic [ADDR_WIDTH-1:0] pcOut,
    output logic                  instrRetired,
    output logic                  trap
);

    localparam logic [2:0] c_FETCH   = 3'd0;
    localparam logic [2:0] c_DECODE  = 3'd1;
    localparam logic [2:0] c_EXECUTE = 3'd2;
    localparam logic [2:0] c_MEM     = 3'd3;
    localparam logic [2:0] c_WB      = 3'd4;
`ifdef MULTI_CYCLE_CPU_TRAP_EN
    localparam logic [2:0] c_HALT    = 3'd5;
`endif

    localparam logic [2:0]            c_LS_F3   = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(4);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_ir;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_imm;
    logic [ADDR_WIDTH-1:0] r_tgt;
    logic [XLEN-1:0]       r_aluOut;
    logic [XLEN-1:0]       r_mdr;
    logic [XLEN-1:0]       r_regs [32];
    logic                  r_retired;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_isRtype;
    logic            w_isAddi;
    logic            w_isLoad;
    logic            w_isStore;
    logic            w_isBeq;
    logic            w_legal;
    logic [XLEN-1:0] w_immI;
    logic [XLEN-1:0] w_immS;
    logic [XLEN-1:0] w_immB;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1Val;
    logic [XLEN-1:0] w_rs2Val;
    logic [XLEN-1:0] w_opB;
    logic [XLEN-1:0] w_aluRes;
    logic            w_memDone;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_rd     = r_ir[11:7];

    assign w_isRtype = (w_opcode == 7'b0110011) &&
                       (((w_f3 == 3'b000) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000))) ||
                        (((w_f3 == 3'b111) || (w_f3 == 3'b110)) && (w_f7 == 7'b0000000)));
    assign w_isAddi  = (w_opcode == 7'b0010011) && (w_f3 == 3'b000);
    assign w_isLoad  = (w_opcode == 7'b0000011) && (w_f3 == c_LS_F3);
    assign w_isStore = (w_opcode == 7'b0100011) && (w_f3 == c_LS_F3);
    assign w_isBeq   = (w_opcode == 7'b1100011) && (w_f3 == 3'b000);
    assign w_legal   = w_isRtype || w_isAddi || w_isLoad || w_isStore || w_isBeq;

    assign w_immI = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_immS = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_immB = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    always_comb begin
        w_imm = w_immI;
        if (w_isStore) begin
            w_imm = w_immS;
        end else if (w_isBeq) begin
            w_imm = w_immB;
        end
    end

    // x0 is never written, but the read side is forced to zero as well
    assign w_rs1Val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2Val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

    always_comb begin
        w_opB    = w_isRtype ? r_b : r_imm;
        w_aluRes = r_a + w_opB;
        if (w_isRtype) begin
            case (w_f3)
                3'b111:  w_aluRes = r_a & r_b;
                3'b110:  w_aluRes = r_a | r_b;
                default: w_aluRes = w_f7[5] ? (r_a - r_b) : (r_a + r_b);
            endcase
        end
    end

    always_comb begin
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        if (!resetInput) begin
            if (r_state == c_FETCH) begin
                memReq  = 1'b1;
                memAddr = r_pc;
            end else if (r_state == c_MEM) begin
                memReq  = 1'b1;
                memWe   = w_isStore;
                memAddr = r_aluOut[ADDR_WIDTH-1:0];
                if (w_isStore) begin
                    memWData = r_b;
                end
            end
        end
    end

    assign w_memDone = memReq && memReady;

    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            r_state   <= c_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_tgt     <= '0;
            r_aluOut  <= '0;
            r_mdr     <= '0;
            r_retired <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retired <= 1'b0;
            case (r_state)
                c_FETCH: begin
                    if (w_memDone) begin
                        r_ir    <= memRData[31:0];
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    r_a   <= w_rs1Val;
                    r_b   <= w_rs2Val;
                    r_imm <= w_imm;
                    r_tgt <= r_pc + w_imm[ADDR_WIDTH-1:0];
                    if (w_legal) begin
                        r_state <= c_EXECUTE;
                    end else begin
`ifdef MULTI_CYCLE_CPU_TRAP_EN
                        r_state <= c_HALT;
`else
                        r_pc      <= r_pc + c_PC_STEP;
                        r_retired <= 1'b1;
                        r_state   <= c_FETCH;
`endif
                    end
                end
                c_EXECUTE: begin
                    r_aluOut <= w_aluRes;
                    if (w_isBeq) begin
                        r_pc      <= (r_a == r_b) ? r_tgt : (r_pc + c_PC_STEP);
                        r_retired <= 1'b1;
                        r_state   <= c_FETCH;
                    end else if (w_isLoad || w_isStore) begin
                        r_state <= c_MEM;
                    end else begin
                        r_state <= c_WB;
                    end
                end
                c_MEM: begin
                    if (w_memDone) begin
                        if (w_isLoad) begin
                            r_mdr   <= memRData;
                            r_state <= c_WB;
                        end else begin
                            r_pc      <= r_pc + c_PC_STEP;
                            r_retired <= 1'b1;
                            r_state   <= c_FETCH;
                        end
                    end
                end
                c_WB: begin
                    if (w_rd != 5'd0) begin
                        r_regs[w_rd] <= w_isLoad ? r_mdr : r_aluOut;
                    end
                    r_pc      <= r_pc + c_PC_STEP;
                    r_retired <= 1'b1;
                    r_state   <= c_FETCH;
                end
`ifdef MULTI_CYCLE_CPU_TRAP_EN
                c_HALT: begin
                    r_state <= c_HALT;
                end
`endif
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

    assign pcOut        = r_pc;
    assign instrRetired = r_retired;

`ifdef MULTI_CYCLE_CPU_TRAP_EN
    assign trap = (r_state == c_HALT);
`else
    assign trap = 1'b0;
`endif

endmodule

`default_nettype wire
